// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD digit limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;

    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic [7:0] count;
    logic [7:0] disp;
    logic       running;
    logic       lap_active;
    logic       at_max;

    modport master (
        output btn_ss, btn_lap, btn_clr,
        input  count, disp, running, lap_active, at_max
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr,
        output count, disp, running, lap_active, at_max
    );

endinterface

// File: rtl/stopwatch_ctrl_bcd2_count.sv
// Two-digit BCD counter; saturates at 99 unless wrap is set, clr has priority over en.
module bcd2_count
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       wrap,
    output logic [7:0] count,
    output logic       at99
);

    logic [3:0] tens;
    logic [3:0] units;

    assign tens  = count[7:4];
    assign units = count[3:0];
    assign at99  = (tens == BCD_MAX_DIGIT) && (units == BCD_MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 8'h00;
        end else if (en) begin
            if (units != BCD_MAX_DIGIT) begin
                count <= {tens, units + 4'd1};
            end else if (tens != BCD_MAX_DIGIT) begin
                count <= {tens + 4'd1, 4'd0};
            end else if (wrap) begin
                count <= 8'h00;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaler, start/stop/lap/clear FSM and lap freeze register.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter bit WRAP     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    count;
    logic          at99;
    logic [7:0]    lap_reg;
    logic          lap_active;
    logic          running;
    logic          at_max;

    assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

    bcd2_count u_count (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .clr   (sw.btn_clr),
        .wrap  (WRAP),
        .count (count),
        .at99  (at99)
    );

    // A tick at 99 without wrap lands in DONE even if btn_ss arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            lap_reg    <= 8'h00;
            lap_active <= 1'b0;
            running    <= 1'b0;
            at_max     <= 1'b0;
        end else if (sw.btn_clr) begin
            state      <= IDLE;
            presc      <= '0;
            lap_active <= 1'b0;
            running    <= 1'b0;
            at_max     <= 1'b0;
        end else begin
            if (state == RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
            end
            case (state)
                IDLE: begin
                    if (sw.btn_ss) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick && at99 && !WRAP) begin
                        state      <= DONE;
                        running    <= 1'b0;
                        at_max     <= 1'b1;
                        lap_active <= 1'b0;
                    end else if (sw.btn_ss) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (sw.btn_lap) begin
                        lap_active <= !lap_active;
                        if (!lap_active) begin
                            lap_reg <= count;
                        end
                    end
                end
                PAUSE: begin
                    if (sw.btn_ss) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (sw.btn_lap) begin
                        lap_active <= !lap_active;
                        if (!lap_active) begin
                            lap_reg <= count;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    at_max  <= 1'b0;
                end
            endcase
        end
    end

    assign sw.count      = count;
    assign sw.disp       = lap_active ? lap_reg : count;
    assign sw.running    = running;
    assign sw.lap_active = lap_active;
    assign sw.at_max     = at_max;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000: clock cycles per count increment (>=2).
REQ-002 Parameter WRAP, default 0: 0 = stop at 99; 1 = wrap 99->00 and keep running.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 btn_ss  in  1  start/stop, one-cycle pulse, already debounced.
REQ-007 btn_lap  in  1  lap freeze/release, one-cycle pulse.
REQ-008 btn_clr  in  1  clear, one-cycle pulse.
REQ-009 count  out  8  live BCD count; tens in [7:4], units in [3:0].
REQ-010 disp  out  8  displayed BCD value: lap_reg when lap_active, else count.
REQ-011 running  out  1  high only in RUN.
REQ-012 lap_active  out  1  display frozen.
REQ-013 at_max  out  1  high only in DONE.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-015 Button priority SHALL be btn_clr > btn_ss > btn_lap when pulses coincide.
REQ-016 IDLE: btn_ss -> RUN; btn_lap ignored.
REQ-017 RUN: btn_ss -> PAUSE; btn_clr -> IDLE.
REQ-018 RUN, WRAP=0: a tick with count==99 -> DONE, with count held at 99.
REQ-019 PAUSE: btn_ss -> RUN; btn_clr -> IDLE.
REQ-020 DONE: btn_clr -> IDLE; btn_ss and btn_lap ignored.
REQ-021 btn_clr in any state SHALL set count=00, prescaler=0, lap_active=0 and state=IDLE on the next edge.
REQ-022 Prescaler range and advance:
- counts 0..TICK_DIV-1, advancing only in RUN.
- at TICK_DIV-1 it SHALL assert tick for one cycle and return to 0.
REQ-023 Prescaler in PAUSE SHALL hold its value, so resume preserves the partial period.
REQ-024 First increment timing: count SHALL show 01 exactly TICK_DIV edges after the edge sampling btn_ss in IDLE with count 00.
REQ-025 Increment on tick:
- units 0..8 -> +1.
- units 9 -> units 0, tens +1.
- 99 -> 00 when WRAP=1.
- digits never hold values above 9.
REQ-026 Tick and btn_ss in the same RUN cycle: increment SHALL apply, then state SHALL go to PAUSE.
REQ-027 Tick and btn_clr together: clear SHALL win and count SHALL be 00.
REQ-028 btn_lap in RUN or PAUSE SHALL toggle lap_active.
REQ-029 On setting lap_active, lap_reg SHALL capture the pre-increment count of that cycle.
REQ-030 lap_active SHALL clear on entry to IDLE or DONE.
REQ-031 Counting SHALL continue while lap_active is high.
REQ-032 Output timing: all outputs except disp SHALL be registered; disp SHALL be a mux of registers.

Reset
REQ-033 rst high at an edge SHALL force: state IDLE, count 00, prescaler 0, lap_reg 00, lap_active 0.
REQ-034 After reset, outputs SHALL read disp=00, running=0, at_max=0.
REQ-035 rst SHALL override all buttons and ticks in the same cycle, mid-run included.

Structure
REQ-036 Package stopwatch_pkg SHALL hold the state encoding and the BCD_MAX_DIGIT=9 constant.
REQ-037 One sub-module, bcd2_count, SHALL be used:
- function: two-digit BCD counter.
- inputs: clk, rst, en, clr, wrap.
- outputs: count[7:0], at99.
- reset: synchronous, active-high.
REQ-038 Prescaler, FSM and lap register SHALL reside in stopwatch_ctrl.

Verification (TICK_DIV=4 unless noted)
REQ-039 Start: btn_ss from reset -> count 01 after 4 edges, 02 after 8; running=1.
REQ-040 Stop at max, WRAP=0: run to 99 -> at_max=1, running=0, count stays 99; btn_ss -> no change; btn_clr -> IDLE, 00.
REQ-041 Wrap, WRAP=1: run to 99 -> next tick count=00, running=1, at_max=0.
REQ-042 Lap freeze: btn_lap at count 23 -> disp 23 while count reaches 27; btn_lap again -> disp=count=27.
REQ-043 Pause resume: btn_ss with prescaler=2, idle 100 cycles, btn_ss -> next increment 2 edges after resume edge.
REQ-044 Conflicts:
- btn_clr+btn_ss together in RUN -> IDLE, count 00.
- rst at count 45 with lap_active -> next edge all outputs zero, state IDLE.
